// File: rtl/tlb_mmu_if.sv
// TLB entry type plus the bundle of CP0 (read/write/probe) and translation-port
// signals between the core and the tlb_mmu block.
package tlb_mmu_pkg;
  typedef struct packed {
    logic [2:0]  c0;
    logic [2:0]  c1;
    logic [7:0]  asid;
    logic [18:0] vpn2;
    logic [19:0] pfn0;
    logic [19:0] pfn1;
    logic        d0;
    logic        v0;
    logic        d1;
    logic        v1;
    logic        g;
  } tlb_entry_t;
endpackage

interface tlb_mmu_if #(parameter int TLB_ENTRIES_NUM = 16);
  localparam int IW = $clog2(TLB_ENTRIES_NUM);

  logic [7:0]              asid;
  logic                    kseg0_uncached;
  logic [IW-1:0]           tlbrw_index;
  logic                    tlbrw_we;
  tlb_mmu_pkg::tlb_entry_t tlbrw_wdata;
  tlb_mmu_pkg::tlb_entry_t tlbrw_rdata;
  logic [31:0]             tlbp_entry_hi;
  logic [31:0]             tlbp_index;

  // Request/response: a port's req sampled high at a rising edge yields
  // resp_valid=1 with its result for exactly the following cycle. There is
  // no ready/backpressure; req may be held high every cycle.
  logic        i_req;
  logic [31:0] i_vaddr;
  logic        i_resp_valid;
  logic [31:0] i_paddr;
  logic        i_uncached;
  logic        i_miss;
  logic        i_invalid;

  logic        d_req;
  logic [31:0] d_vaddr;
  logic        d_store;
  logic        d_resp_valid;
  logic [31:0] d_paddr;
  logic        d_uncached;
  logic        d_miss;
  logic        d_invalid;
  logic        d_mod;

  modport master (
    output asid, kseg0_uncached, tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi,
           i_req, i_vaddr, d_req, d_vaddr, d_store,
    input  tlbrw_rdata, tlbp_index,
           i_resp_valid, i_paddr, i_uncached, i_miss, i_invalid,
           d_resp_valid, d_paddr, d_uncached, d_miss, d_invalid, d_mod
  );

  modport slave (
    input  asid, kseg0_uncached, tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi,
           i_req, i_vaddr, d_req, d_vaddr, d_store,
    output tlbrw_rdata, tlbp_index,
           i_resp_valid, i_paddr, i_uncached, i_miss, i_invalid,
           d_resp_valid, d_paddr, d_uncached, d_miss, d_invalid, d_mod
  );
endinterface

// File: rtl/tlb_mmu.sv
// Joint TLB + address translation: CP0 read/write/probe of the entry array and
// one-cycle registered translation for the instruction and data ports.
module tlb_mmu
  import tlb_mmu_pkg::*;
#(
  parameter int TLB_ENTRIES_NUM = 16
) (
  input logic     clk,
  input logic     resetn,
  tlb_mmu_if.slave bus
);
  localparam int IW = $clog2(TLB_ENTRIES_NUM);

  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    logic        miss;
    logic        invalid;
    logic        mod;
  } xlate_t;

  tlb_entry_t entries [TLB_ENTRIES_NUM];

  function automatic logic entry_match(input tlb_entry_t e, input logic [18:0] vpn2,
                                       input logic [7:0] cur_asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == cur_asid));
  endfunction

  // Lowest matching index wins, so scan downwards and keep the last hit.
  function automatic logic [IW:0] first_hit(input logic [TLB_ENTRIES_NUM-1:0] hit);
    logic [IW:0] r;
    r = '0;
    for (int k = TLB_ENTRIES_NUM - 1; k >= 0; k--) begin
      if (hit[k]) r = {1'b1, IW'(k)};
    end
    return r;
  endfunction

  function automatic xlate_t translate(input tlb_entry_t e, input logic found,
                                       input logic [31:0] va, input logic store,
                                       input logic k0_unc);
    xlate_t     r;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        v;
    logic        d;
    r   = '0;
    pfn = va[12] ? e.pfn1 : e.pfn0;
    c   = va[12] ? e.c1   : e.c0;
    v   = va[12] ? e.v1   : e.v0;
    d   = va[12] ? e.d1   : e.d0;
    case (va[31:29])
      3'b100: begin
        r.paddr    = {3'b000, va[28:0]};
        r.uncached = k0_unc;
      end
      3'b101: begin
        r.paddr    = {3'b000, va[28:0]};
        r.uncached = 1'b1;
      end
      default: begin
        r.paddr    = {pfn, va[11:0]};
        r.uncached = (c != 3'd3);
        if (!found)      r.miss    = 1'b1;
        else if (!v)     r.invalid = 1'b1;
        else if (store)  r.mod     = ~d;
      end
    endcase
    return r;
  endfunction

  logic [TLB_ENTRIES_NUM-1:0] i_hit, d_hit, p_hit;
  logic [IW:0]                i_sel, d_sel, p_sel;
  xlate_t                     i_res, d_res;

  always_comb begin
    i_hit = '0;
    d_hit = '0;
    p_hit = '0;
    for (int k = 0; k < TLB_ENTRIES_NUM; k++) begin
      i_hit[k] = entry_match(entries[k], bus.i_vaddr[31:13], bus.asid);
      d_hit[k] = entry_match(entries[k], bus.d_vaddr[31:13], bus.asid);
      p_hit[k] = entry_match(entries[k], bus.tlbp_entry_hi[31:13], bus.tlbp_entry_hi[7:0]);
    end
  end

  assign i_sel = first_hit(i_hit);
  assign d_sel = first_hit(d_hit);
  assign p_sel = first_hit(p_hit);

  assign i_res = translate(entries[i_sel[IW-1:0]], i_sel[IW], bus.i_vaddr, 1'b0,
                           bus.kseg0_uncached);
  assign d_res = translate(entries[d_sel[IW-1:0]], d_sel[IW], bus.d_vaddr, bus.d_store,
                           bus.kseg0_uncached);

  // Read and probe see the array before any write landing at this edge.
  assign bus.tlbrw_rdata = entries[bus.tlbrw_index];
  assign bus.tlbp_index  = p_sel[IW] ? 32'(p_sel[IW-1:0]) : 32'h8000_0000;

  logic   i_valid_q, d_valid_q;
  xlate_t i_res_q, d_res_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < TLB_ENTRIES_NUM; k++) entries[k] <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_res_q   <= '0;
      d_res_q   <= '0;
    end else begin
      if (bus.tlbrw_we) entries[bus.tlbrw_index] <= bus.tlbrw_wdata;
      i_valid_q <= bus.i_req;
      d_valid_q <= bus.d_req;
      // Results hold their last value while the port is idle.
      if (bus.i_req) i_res_q <= i_res;
      if (bus.d_req) d_res_q <= d_res;
    end
  end

  assign bus.i_resp_valid = i_valid_q;
  assign bus.i_paddr      = i_res_q.paddr;
  assign bus.i_uncached   = i_res_q.uncached;
  assign bus.i_miss       = i_res_q.miss;
  assign bus.i_invalid    = i_res_q.invalid;

  assign bus.d_resp_valid = d_valid_q;
  assign bus.d_paddr      = d_res_q.paddr;
  assign bus.d_uncached   = d_res_q.uncached;
  assign bus.d_miss       = d_res_q.miss;
  assign bus.d_invalid    = d_res_q.invalid;
  assign bus.d_mod        = d_res_q.mod;

  logic unused_bits;
  assign unused_bits = ^{bus.tlbp_entry_hi[12:8], i_res_q.mod};
endmodule

// File: tb/tb_tlb_mmu.sv
// Self-checking bench for tlb_mmu: directed CP0 writes/probes and translation
// requests, with expected responses queued per port and compared on output.
module tb_tlb_mmu;
  import tlb_mmu_pkg::*;

  localparam int W = 37;  // {check_addr, paddr[31:0], uncached, miss, invalid, mod}

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic mon_en = 1'b0;
  logic exp_i_valid = 1'b0;
  logic exp_d_valid = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [W-1:0] i_q[$];
  logic [W-1:0] d_q[$];

  tlb_mmu_if #(.TLB_ENTRIES_NUM(16)) bus ();

  tlb_mmu #(.TLB_ENTRIES_NUM(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no end of test, want end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_exp(input logic chk, input logic [31:0] pa,
                                          input logic unc, input logic miss,
                                          input logic inv, input logic mod);
    return {chk, pa, unc, miss, inv, mod};
  endfunction

  function automatic tlb_entry_t mk_entry(input logic [18:0] vpn2, input logic [7:0] a,
                                          input logic g,
                                          input logic [19:0] pfn0, input logic [2:0] c0,
                                          input logic v0, input logic d0,
                                          input logic [19:0] pfn1, input logic [2:0] c1,
                                          input logic v1, input logic d1);
    tlb_entry_t e;
    e.c0 = c0; e.c1 = c1; e.asid = a; e.vpn2 = vpn2;
    e.pfn0 = pfn0; e.pfn1 = pfn1;
    e.d0 = d0; e.v0 = v0; e.d1 = d1; e.v1 = v1; e.g = g;
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    exp_i_valid <= resetn && bus.i_req;
    exp_d_valid <= resetn && bus.d_req;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("i_resp_valid", 128'(bus.i_resp_valid), 128'(exp_i_valid));
      if (exp_i_valid && i_q.size() > 0) begin
        if (i_q[0][36]) begin
          check("i_paddr", 128'(bus.i_paddr), 128'(i_q[0][35:4]));
          check("i_uncached", 128'(bus.i_uncached), 128'(i_q[0][3]));
        end
        check("i_miss", 128'(bus.i_miss), 128'(i_q[0][2]));
        check("i_invalid", 128'(bus.i_invalid), 128'(i_q[0][1]));
        void'(i_q.pop_front());
      end
      check("d_resp_valid", 128'(bus.d_resp_valid), 128'(exp_d_valid));
      if (exp_d_valid && d_q.size() > 0) begin
        if (d_q[0][36]) begin
          check("d_paddr", 128'(bus.d_paddr), 128'(d_q[0][35:4]));
          check("d_uncached", 128'(bus.d_uncached), 128'(d_q[0][3]));
        end
        check("d_miss", 128'(bus.d_miss), 128'(d_q[0][2]));
        check("d_invalid", 128'(bus.d_invalid), 128'(d_q[0][1]));
        check("d_mod", 128'(bus.d_mod), 128'(d_q[0][0]));
        void'(d_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic d_access(input logic [31:0] va, input logic st, input logic [W-1:0] e);
    bus.d_req = 1'b1;
    bus.d_vaddr = va;
    bus.d_store = st;
    d_q.push_back(e);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    bus.d_store = 1'b0;
  endtask

  task automatic i_access(input logic [31:0] va, input logic [W-1:0] e);
    bus.i_req = 1'b1;
    bus.i_vaddr = va;
    i_q.push_back(e);
    @(posedge clk); #1;
    bus.i_req = 1'b0;
  endtask

  task automatic write_entry(input logic [3:0] idx, input tlb_entry_t e);
    bus.tlbrw_index = idx;
    bus.tlbrw_wdata = e;
    bus.tlbrw_we = 1'b1;
    @(posedge clk); #1;
    bus.tlbrw_we = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [31:0] hi, input logic [31:0] exp);
    bus.tlbp_entry_hi = hi;
    #1;
    check(tag, 128'(bus.tlbp_index), 128'(exp));
  endtask

  // ---------------- stimulus ----------------
  tlb_entry_t e5, e2, e7, e9;
  logic [W-1:0] miss_e;

  initial begin
    miss_e = mk_exp(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.asid = 8'h00; bus.kseg0_uncached = 1'b0;
    bus.tlbrw_index = '0; bus.tlbrw_we = 1'b0; bus.tlbrw_wdata = '0;
    bus.tlbp_entry_hi = 32'h0;
    bus.i_req = 1'b0; bus.i_vaddr = 32'h0;
    bus.d_req = 1'b0; bus.d_vaddr = 32'h0; bus.d_store = 1'b0;

    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;
    check("rst_i_resp_valid", 128'(bus.i_resp_valid), 128'(0));
    check("rst_d_resp_valid", 128'(bus.d_resp_valid), 128'(0));
    check("rst_d_paddr", 128'(bus.d_paddr), 128'(0));
    check("rst_i_paddr", 128'(bus.i_paddr), 128'(0));
    check("rst_d_flags", 128'({bus.d_uncached, bus.d_miss, bus.d_invalid, bus.d_mod}), 128'(0));
    check("rst_i_flags", 128'({bus.i_uncached, bus.i_miss, bus.i_invalid}), 128'(0));

    // Empty TLB: mapped accesses miss, probe misses.
    d_access(32'h0040_0000, 1'b0, miss_e);
    i_access(32'hC000_0000, miss_e);
    probe("tlbp_after_reset", 32'h0040_0000, 32'h8000_0000);

    // Entry 5: even page valid/dirty cacheable, odd page invalid.
    e5 = mk_entry(19'h00200, 8'h12, 1'b0, 20'h01234, 3'd3, 1'b1, 1'b1,
                  20'h05678, 3'd3, 1'b0, 1'b0);
    write_entry(4'd5, e5);
    bus.asid = 8'h12;
    d_access(32'h0040_0ABC, 1'b0, mk_exp(1'b1, 32'h0123_4ABC, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.asid = 8'h13;
    d_access(32'h0040_0ABC, 1'b0, miss_e);
    bus.asid = 8'h12;
    d_access(32'h0040_1000, 1'b0, mk_exp(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Odd page valid but clean: store faults, load translates.
    e5.v1 = 1'b1;
    write_entry(4'd5, e5);
    d_access(32'h0040_1000, 1'b1, mk_exp(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    d_access(32'h0040_1000, 1'b0, mk_exp(1'b1, 32'h0567_8000, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    check("d_paddr_hold", 128'(bus.d_paddr), 128'(32'h0567_8000));
    probe("tlbp_hit5", 32'h0040_0012, 32'h0000_0005);
    probe("tlbp_asid_miss", 32'h0040_0013, 32'h8000_0000);
    bus.tlbrw_index = 4'd5;
    #1;
    check("tlbr_5", 128'(bus.tlbrw_rdata), 128'(e5));

    // Unmapped segments.
    bus.kseg0_uncached = 1'b0;
    i_access(32'h8000_1000, mk_exp(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.kseg0_uncached = 1'b1;
    i_access(32'h8000_1000, mk_exp(1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 1'b0));
    bus.kseg0_uncached = 1'b0;
    i_access(32'hBFC0_0000, mk_exp(1'b1, 32'h1FC0_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    d_access(32'hA000_0040, 1'b1, mk_exp(1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0));

    // Duplicate global entries: lowest index wins.
    e2 = mk_entry(19'h00400, 8'h00, 1'b1, 20'h0AAAA, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    e7 = mk_entry(19'h00400, 8'h77, 1'b1, 20'h0BBBB, 3'd2, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    write_entry(4'd2, e2);
    write_entry(4'd7, e7);
    bus.asid = 8'h55;
    d_access(32'h0080_0010, 1'b0, mk_exp(1'b1, 32'h0AAA_A010, 1'b0, 1'b0, 1'b0, 1'b0));
    probe("tlbp_dup", 32'h0080_0000, 32'h0000_0002);
    bus.tlbrw_index = 4'd7;
    #1;
    check("tlbr_7", 128'(bus.tlbrw_rdata), 128'(e7));

    // Write and lookup in the same cycle: lookup and probe see old contents.
    e9 = mk_entry(19'h00600, 8'h00, 1'b1, 20'h00ABC, 3'd2, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    bus.tlbrw_index = 4'd9;
    bus.tlbrw_wdata = e9;
    bus.tlbrw_we = 1'b1;
    probe("tlbp_prewrite", 32'h00C0_0000, 32'h8000_0000);
    d_access(32'h00C0_0044, 1'b0, miss_e);
    bus.tlbrw_we = 1'b0;
    d_access(32'h00C0_0044, 1'b0, mk_exp(1'b1, 32'h00AB_C044, 1'b1, 1'b0, 1'b0, 1'b0));

    // Reset while requests are streaming.
    bus.d_req = 1'b1; bus.d_vaddr = 32'hA000_0100;
    bus.i_req = 1'b1; bus.i_vaddr = 32'h8000_0200;
    d_q.push_back(mk_exp(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0));
    i_q.push_back(mk_exp(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    check("rst2_d_paddr", 128'(bus.d_paddr), 128'(0));
    check("rst2_i_resp_valid", 128'(bus.i_resp_valid), 128'(0));
    bus.asid = 8'h12;
    d_access(32'h0040_0ABC, 1'b0, miss_e);
    d_access(32'h0080_0010, 1'b0, miss_e);
    probe("tlbp_after_rst2", 32'h0080_0000, 32'h8000_0000);
    bus.tlbrw_index = 4'd5;
    #1;
    check("tlbr_5_rst2_valid", 128'({bus.tlbrw_rdata.v0, bus.tlbrw_rdata.v1, bus.tlbrw_rdata.g}),
          128'(0));

    repeat (3) @(posedge clk);
    #1;
    check("i_q_leftover", 128'(i_q.size()), 128'(0));
    check("d_q_leftover", 128'(d_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tlb_mmu.md
# tlb_mmu

Joint TLB and address-translation unit for the MIPS core: holds the TLB entries, serves the CP0 side of the TLB interface (TLBR/TLBWI/TLBWR read/write, TLBP probe), and translates virtual addresses for the instruction-fetch and data-memory ports. The translation result is registered, with one cycle of latency. Fault classification (refill, invalid, modified) goes to the pipeline's exception logic, which produces the EXCCODE_TLBL/TLBS/MOD exceptions and the tlb_refill flag.

## Interface
- TLB_ENTRIES_NUM, 16, number of entries; index width IW = $clog2(TLB_ENTRIES_NUM).
- clk  in  1  core clock; all state changes on the rising edge.
- resetn  in  1  reset; one clock, synchronous, active-low.
- asid  in  8  current ASID (EntryHi[7:0]) used by both translation ports.
- kseg0_uncached  in  1  kseg0 accesses are uncached when 1.
- tlbrw_index  in  IW  entry selected for read/write.
- tlbrw_we  in  1  write tlbrw_wdata into entry tlbrw_index at the clock edge.
- tlbrw_wdata  in  tlb_entry_t  {c0,c1,asid,vpn2,pfn0,pfn1,d0,v0,d1,v1,G}.
- tlbrw_rdata  out  tlb_entry_t  contents of entry tlbrw_index (combinational).
- tlbp_entry_hi  in  32  probe key: VPN2 = [31:13], ASID = [7:0].
- tlbp_index  out  32  probe result (combinational): hit = {1'b0, zero-extended index}; miss = 32'h8000_0000.
- i_req, d_req  in  1  translation request on the instruction/data port.
- i_vaddr, d_vaddr  in  32  virtual address.
- d_store  in  1  the data request is a store.
- i_resp_valid, d_resp_valid  out  1  result valid, one cycle after the request.
- i_paddr, d_paddr  out  32  physical address.
- i_uncached, d_uncached  out  1  access bypasses the cache.
- i_miss, d_miss  out  1  TLB refill fault (no matching entry).
- i_invalid, d_invalid  out  1  an entry matched but the selected page has V=0.
- d_mod  out  1  store to a valid page with D=0.

## Operation
- Entry match: vpn2 == vaddr[31:13] && (G || entry.asid == asid). The odd/even page is chosen by vaddr[12] (1 selects pfn1/c1/d1/v1).
- If several entries match, the lowest index wins. This applies to translation and to TLBP; software must prevent it.
- Segments:
  - kuseg (vaddr[31]=0) and kseg2/kseg3 (vaddr[31:30]=2'b11) are mapped.
  - kseg0 (3'b100): paddr = {3'b000, vaddr[28:0]}, uncached = kseg0_uncached.
  - kseg1 (3'b101): same paddr, uncached = 1.
  - Unmapped accesses never raise miss, invalid or mod.
- Mapped access:
  - paddr = {pfn, vaddr[11:0]}.
  - uncached = (c != 3'd3).
  - Fault priority: miss > invalid > mod. mod is only possible on d_store.
  - When a fault is flagged, paddr and uncached are don't-care; the bench checks only the flags.
- Write: at the edge where tlbrw_we=1, entry[tlbrw_index] <= tlbrw_wdata, all fields including G.
- Read and probe are purely combinational from the current entry array. CP0 samples them in the same cycle it issues TLBR or TLBP.
- Reset: every entry's v0, v1, d0, d1 and G are cleared and asid/vpn2 are zeroed. After reset every mapped access returns miss.

## Timing
- Translation latency is 1 cycle. A request sampled at edge N produces resp_valid and the result registers during cycle N+1.
- With req=0, resp_valid drops to 0 the next cycle. The paddr, uncached and fault flags hold their last values.
- Requests may be issued every cycle on both ports independently; there is no backpressure.
- Write vs. lookup in the same cycle: the lookup uses the pre-write contents. The new entry is visible to requests sampled at the following edge and later.
- Write vs. read/probe in the same cycle: tlbrw_rdata and tlbp_index reflect the pre-write contents.
- Reset output values: i_resp_valid and d_resp_valid = 0; paddr = 0; uncached, miss, invalid, mod = 0.
- resetn low while a request is in flight: the response is dropped and resp_valid = 0 on the next cycle.
- asid and kseg0_uncached are sampled at the same edge as the request.

## Test plan
- After reset: d_req with vaddr 0x0040_0000 -> next cycle d_resp_valid=1, d_miss=1. tlbp_entry_hi=0x0040_0000 -> tlbp_index=0x8000_0000.
- Write index 5: vpn2=0x00200 (va 0x0040_0000), asid=0x12, G=0, pfn0=0x01234 with c0=3, v0=1, d0=1. Then with asid=0x12, d_req vaddr 0x0040_0ABC -> paddr 0x0123_4ABC, uncached=0, no faults. Same access with asid=0x13 -> d_miss=1.
- Same entry with pfn1 page v1=0: d_req vaddr 0x0040_1000 -> d_invalid=1. Set v1=1, d1=0, then a store (d_store=1) to 0x0040_1000 -> d_mod=1, while a load to the same address -> no fault.
- Segments: i_vaddr 0x8000_1000 with kseg0_uncached=0 -> i_paddr 0x0000_1000, i_uncached=0. Same with kseg0_uncached=1 -> i_uncached=1. i_vaddr 0xBFC0_0000 -> i_paddr 0x1FC0_0000, i_uncached=1.
- Duplicate entries: entries 2 and 7 both match with different pfn0 -> translation uses entry 2 and tlbp_index=0x0000_0002. tlbrw_index=7 -> tlbrw_rdata equals the data written to entry 7.
- Same-cycle write and lookup to a new VPN -> that response misses, the next-cycle request hits. Pulse resetn low with back-to-back requests -> resp_valid=0 next cycle and all entries invalid afterwards.
